// File: rtl/pc_sequencer.sv
// Next-PC unit: PC register, return-address stack, halt/resume FSM and sticky stack errors. One-cycle latency.
// A stall holds PC, RAS and FSM state. Define PC_TRAP_EN to redirect stack errors to TRAP_VEC and pulse trap.
module pc_sequencer #(
  parameter int unsigned          ADDR_W      = 12,
  parameter int unsigned          OFFSET_W    = 8,
  parameter int unsigned          STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]    RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0]    TRAP_VEC    = 12'hFF0,
  localparam int unsigned         SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                jmp,
  input  logic                jsb,
  input  logic                ret,
  input  logic [ADDR_W-1:0]   jmp_addr,
  input  logic                halt,
  input  logic                resume,
  input  logic                err_clr,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus1,
  output logic [SP_W-1:0]     sp,
  output logic                stk_full,
  output logic                stk_empty,
  output logic                ovf_err,
  output logic                unf_err,
  output logic                halted,
  output logic                trap
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned EXT_W = ADDR_W - OFFSET_W;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              trap_d;
  logic              push;
  logic              err_ev;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] br_ext;
  logic [ADDR_W-1:0] ras_q [STACK_DEPTH];

  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign br_ext    = {{EXT_W{br_offset[OFFSET_W-1]}}, br_offset};
  assign rd_idx    = IDX_W'(sp_q - SP_W'(1));
  assign wr_idx    = IDX_W'(sp_q);
  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    trap_d  = 1'b0;
    push    = 1'b0;
    err_ev  = 1'b0;

    // Clear first so that a same-cycle error event below wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_HALT;
          end else if (ret) begin
            if (!stk_empty) begin
              pc_d = ras_q[rd_idx];
              sp_d = sp_q - SP_W'(1);
            end else begin
              unf_d  = 1'b1;
              err_ev = 1'b1;
              pc_d   = pc_plus1;
            end
          end else if (jsb) begin
            pc_d = jmp_addr;
            if (!stk_full) begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
            end else begin
              ovf_d  = 1'b1;
              err_ev = 1'b1;
            end
          end else if (jmp) begin
            pc_d = jmp_addr;
          end else if (branch) begin
            pc_d = pc_plus1 + br_ext;
          end else begin
            pc_d = pc_plus1;
          end
`ifdef PC_TRAP_EN
          if (err_ev) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end
`endif
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset; only sp qualifies them.
  always_ff @(posedge clk) begin
    if (push) ras_q[wr_idx] <= pc_plus1;
  end

`ifdef PC_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trap_q <= 1'b0;
    else      trap_q <= trap_d;
  end
  assign trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = ^{TRAP_VEC, trap_d, err_ev};
  assign trap        = 1'b0;
`endif

  assign pc      = pc_q;
  assign sp      = sp_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_VEC = 0x010; trap expectations follow PC_TRAP_EN.
module tb_pc_sequencer;

`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch, jmp, jsb, ret, halt, resume, err_clr;
  logic [7:0]  br_offset;
  logic [11:0] jmp_addr;
  logic [11:0] pc, pc_plus1;
  logic [3:0]  sp;
  logic        stk_full, stk_empty, ovf_err, unf_err, halted, trap;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.RESET_VEC(12'h010)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .br_offset(br_offset),
    .jmp(jmp), .jsb(jsb), .ret(ret), .jmp_addr(jmp_addr), .halt(halt),
    .resume(resume), .err_clr(err_clr), .pc(pc), .pc_plus1(pc_plus1), .sp(sp),
    .stk_full(stk_full), .stk_empty(stk_empty), .ovf_err(ovf_err),
    .unf_err(unf_err), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; jmp = 0; jsb = 0; ret = 0;
    halt = 0; resume = 0; err_clr = 0; br_offset = '0; jmp_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jmp(input logic [11:0] a);
    jmp = 1; jmp_addr = a; tick(); idle();
  endtask

  task automatic do_jsb(input logic [11:0] a);
    jsb = 1; jmp_addr = a; tick(); idle();
  endtask

  task automatic do_ret();
    ret = 1; tick(); idle();
  endtask

  logic [11:0] exp_pc;

  initial begin
    idle();
    rst = 0;
    #12;
    chk("rst_pc", pc, 12'h010);
    chk("rst_sp", sp, 0);
    chk("rst_empty", stk_empty, 1);
    chk("rst_full", stk_full, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_unf", unf_err, 0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap, 0);
    rst = 1;

    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc, 12'h010 + i);
    end
    chk("seq_plus1", pc_plus1, 12'h014);
    chk("seq_sp", sp, 0);

    do_jmp(12'h020);
    chk("jmp_pc", pc, 12'h020);
    branch = 1; br_offset = 8'hFE; tick(); idle();
    chk("branch_neg", pc, 12'h01F);
    branch = 1; br_offset = 8'h10; tick(); idle();
    chk("branch_pos", pc, 12'h030);

    do_jmp(12'hFFF);
    chk("wrap_plus1", pc_plus1, 12'h000);
    tick();
    chk("wrap_pc", pc, 12'h000);

    do_jmp(12'h005);
    do_jsb(12'h100);
    chk("call1_pc", pc, 12'h100);
    chk("call1_sp", sp, 1);
    do_jsb(12'h200);
    chk("call2_pc", pc, 12'h200);
    chk("call2_sp", sp, 2);
    do_ret();
    chk("ret1_pc", pc, 12'h101);
    chk("ret1_sp", sp, 1);
    do_ret();
    chk("ret2_pc", pc, 12'h006);
    chk("ret2_sp", sp, 0);
    chk("ret2_empty", stk_empty, 1);

    // Fill: pushes 007, 301, 311, ... 361; the ninth call overflows.
    for (int i = 0; i < 8; i++) do_jsb(12'h300 + 12'(i * 16));
    chk("fill_sp", sp, 8);
    chk("fill_full", stk_full, 1);
    chk("fill_ovf", ovf_err, 0);
    do_jsb(12'h380);
    exp_pc = TRAP ? 12'hFF0 : 12'h380;
    chk("ovf_pc", pc, exp_pc);
    chk("ovf_sp", sp, 8);
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_trap", trap, TRAP);
    tick();
    chk("ovf_trap_end", trap, 0);

    for (int k = 0; k < 8; k++) begin
      do_ret();
      exp_pc = (k < 7) ? 12'h361 - 12'(k * 16) : 12'h007;
      chk("pop_pc", pc, exp_pc);
      chk("pop_sp", sp, 7 - k);
    end
    chk("pop_unf", unf_err, 0);
    do_ret();
    exp_pc = TRAP ? 12'hFF0 : 12'h008;
    chk("unf_pc", pc, exp_pc);
    chk("unf_sp", sp, 0);
    chk("unf_flag", unf_err, 1);
    chk("unf_ovf_kept", ovf_err, 1);
    chk("unf_trap", trap, TRAP);
    err_clr = 1; tick(); idle();
    chk("clr_ovf", ovf_err, 0);
    chk("clr_unf", unf_err, 0);
    chk("clr_trap", trap, 0);

    // A set event in the same cycle as err_clr keeps the flag set.
    ret = 1; err_clr = 1; tick(); idle();
    chk("set_wins", unf_err, 1);
    err_clr = 1; tick(); idle();

    do_jmp(12'h040);
    stall = 1; jsb = 1; jmp_addr = 12'h500;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc", pc, 12'h040);
      chk("stall_sp", sp, 0);
    end
    idle();

    halt = 1; tick(); idle();
    chk("halt_enter", halted, 1);
    chk("halt_pc", pc, 12'h040);
    jmp = 1; jmp_addr = 12'h777;
    for (int i = 0; i < 5; i++) tick();
    idle();
    chk("halt_hold_pc", pc, 12'h040);
    chk("halt_hold", halted, 1);
    resume = 1; tick(); idle();
    chk("resume_state", halted, 0);
    chk("resume_pc", pc, 12'h040);
    tick();
    chk("resume_step", pc, 12'h041);

    do_jsb(12'h600);
    chk("prio_push_sp", sp, 1);
    ret = 1; jsb = 1; jmp_addr = 12'h700; tick(); idle();
    chk("prio_ret_pc", pc, 12'h042);
    chk("prio_ret_sp", sp, 0);

    do_jsb(12'h123);
    chk("pre_rst_sp", sp, 1);
    jsb = 1; jmp_addr = 12'h456;
    #2 rst = 0;
    #1;
    chk("arst_pc", pc, 12'h010);
    chk("arst_sp", sp, 0);
    chk("arst_empty", stk_empty, 1);
    idle();
    #3 rst = 1;
    tick();
    chk("post_rst_pc", pc, 12'h011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-PC unit for the next CPU generation. Replaces the fixed 12-bit PC register, the +1 and branch adders, the jump/return mux chain and the single-level subroutine stack.
- Owns the PC register and a configurable-depth return-address stack (RAS).
- Adds a stall hold, a halt/resume FSM, and stack full/empty status with sticky overflow/underflow error flags.
- Sits between the control unit (control strobes) and instruction memory (drives the fetch address).

Parameters:
- ADDR_W, 12, PC / instruction address width.
- OFFSET_W, 8, branch offset width; two's complement, sign-extended to ADDR_W.
- STACK_DEPTH, 8, RAS entries; must be ≥ 1.
- RESET_VEC, 0, PC value on reset.
- TRAP_VEC, 12'hFF0, PC target on a stack error; used only with PC_TRAP_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- stall  input  1  hold PC, RAS and FSM this cycle.
- branch  input  1  taken conditional branch.
- br_offset  input  OFFSET_W  signed branch offset.
- jmp  input  1  absolute jump.
- jsb  input  1  call: push return address, then jump.
- ret  input  1  return: pop top of RAS into PC.
- jmp_addr  input  ADDR_W  jump/call target.
- halt  input  1  enter HALT.
- resume  input  1  leave HALT.
- err_clr  input  1  clear sticky error flags.
- pc  output  ADDR_W  current fetch address.
- pc_plus1  output  ADDR_W  pc+1, modulo 2^ADDR_W (combinational).
- sp  output  $clog2(STACK_DEPTH+1)  number of valid RAS entries.
- stk_full  output  1  sp == STACK_DEPTH.
- stk_empty  output  1  sp == 0.
- ovf_err  output  1  sticky; a call was made while the RAS was full.
- unf_err  output  1  sticky; a return was made while the RAS was empty.
- halted  output  1  FSM is in HALT.
- trap  output  1  one-cycle pulse on a stack error (PC_TRAP_EN builds only).

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = RESET_VEC, sp = 0, state = RUN.
  - ovf_err = unf_err = trap = halted = 0, stk_empty = 1, stk_full = 0.
  - RAS contents are don't-care.
- FSM states:
  - RUN → HALT when halt = 1 and stall = 0. pc is not updated that cycle.
  - HALT → RUN when resume = 1. pc is unchanged on exit; sequencing continues from pc next cycle.
  - In HALT, all flow controls and stall are ignored; pc and RAS hold.
  - halt has priority over the flow controls in the same cycle.
- Stall: in RUN with stall = 1, pc, sp, RAS and error flags hold; flow controls are ignored. err_clr still acts.
- Next-PC in RUN, stall = 0. Priority when several controls are asserted: ret > jsb > jmp > branch > sequential.
  - ret, sp > 0: pc <= RAS[sp-1]; sp <= sp-1.
  - ret, sp == 0: unf_err <= 1; pc <= pc+1; sp stays 0.
  - jsb, sp < DEPTH: RAS[sp] <= pc+1; sp <= sp+1; pc <= jmp_addr.
  - jsb, sp == DEPTH: ovf_err <= 1; push dropped, RAS unchanged; pc <= jmp_addr.
  - jmp: pc <= jmp_addr.
  - branch: pc <= pc + 1 + sext(br_offset).
  - none: pc <= pc+1.
- Arithmetic: all address arithmetic is modulo 2^ADDR_W, with no carry out. pc = all-ones sequences to 0.
- Latency: one cycle from control to new pc. The RAS write and read take effect in the same edge as the pc update.
- Error flags: set only as above. err_clr = 1 clears both flags. If a set event and err_clr occur in the same cycle, the set wins.
- stk_full and stk_empty are decoded combinationally from the sp register.

Optional Feature:
- PC_TRAP_EN defined:
  - On a stack error event (overflow or underflow) in RUN, pc <= TRAP_VEC instead of the targets listed above.
  - trap is 1 for exactly the following cycle.
  - Flags are set as normal; RAS and sp are handled as in the non-trap case.
- PC_TRAP_EN not defined: trap is tied to 0 and TRAP_VEC is unused.

Test Plan:
- Reset with RESET_VEC = 0x010, release, 3 idle cycles → pc = 0x010, 0x011, 0x012, 0x013; sp = 0; stk_empty = 1.
- At pc = 0x020: branch with br_offset = 0xFE → pc = 0x01F. At pc = 0xFFF, sequential step → pc = 0x000.
- Nested calls: jsb to 0x100 at pc 0x005, then jsb to 0x200 at pc 0x100, then ret, ret → pc = 0x200, 0x101, 0x006; sp = 1, 2, 1, 0.
- Default depth 8: nine jsb → sp = 8, stk_full = 1, ovf_err = 1, pc = 9th target. Nine ret → first 8 pop correctly, 9th sets unf_err. err_clr → both flags 0.
- stall held 4 cycles while jsb = 1 → pc and sp unchanged. halt, 5 cycles, resume → pc held, then resumes +1 after HALT exit. ret + jsb together → ret taken.
- PC_TRAP_EN build: ret with sp = 0 → pc = 0xFF0, trap pulses 1 cycle, unf_err = 1. Async rst asserted mid-call → pc = RESET_VEC, sp = 0 immediately, without waiting for a clock edge.
